// File: rtl/gf_pow_seq.sv
// gf_pow_seq: r = a^e over GF(2^8) by left-to-right square-and-multiply.
// Drives an external combinational GF(2^8) multiplier once per clock and
// owns that multiplier's reduction-polynomial register. a^254 = a^-1.
module gf_pow_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [7:0] exp_in,
  input  logic       poly_we,
  input  logic [7:0] poly_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic [7:0] mul_a,
  output logic [7:0] mul_b,
  output logic [7:0] mul_g,
  output logic [7:0] mul_f,
  input  logic [7:0] mul_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] base;
  logic [7:0] e;
  logic [7:0] r;
  logic [2:0] idx;
  logic [7:0] poly;

  assign mul_g = poly;
  assign mul_f = '0;

  // Multiplier operands: square r in SQR, r*base in MUL, idle otherwise.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SQR: begin
        mul_a = r;
        mul_b = r;
      end
      MUL: begin
        mul_a = r;
        mul_b = base;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  // Controller FSM with registered busy/done/dout and the poly register.
  // dout is loaded from mul_p on the edge entering DONE (the same value r
  // takes), so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      e     <= '0;
      r     <= '0;
      idx   <= '0;
      poly  <= POLY;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (poly_we) poly <= poly_in;
          if (start) begin
            base  <= din;
            e     <= exp_in;
            r     <= 8'h01;
            idx   <= 3'd7;
            busy  <= 1'b1;
            state <= SQR;
          end
        end
        SQR: begin
          r <= mul_p;
          if (e[idx]) begin
            state <= MUL;
          end else if (idx == 3'd0) begin
            state <= DONE;
            done  <= 1'b1;
            dout  <= mul_p;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        MUL: begin
          r <= mul_p;
          if (idx == 3'd0) begin
            state <= DONE;
            done  <= 1'b1;
            dout  <= mul_p;
          end else begin
            idx   <= idx - 3'd1;
            state <= SQR;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_pow_seq.sv
// tb_gf_pow_seq: directed tests of gf_pow_seq with a behavioural model of
// the external 8-stage LSB-first GF(2^8) multiplier array.
module tb_gf_pow_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic [7:0] exp_in;
  logic       poly_we;
  logic [7:0] poly_in;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic [7:0] mul_a;
  logic [7:0] mul_b;
  logic [7:0] mul_g;
  logic [7:0] mul_f;
  logic [7:0] mul_p;

  int unsigned n_cmp;
  int unsigned n_err;

  gf_pow_seq #(.POLY(8'h1B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .din     (din),
    .exp_in  (exp_in),
    .poly_we (poly_we),
    .poly_in (poly_in),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_g   (mul_g),
    .mul_f   (mul_f),
    .mul_p   (mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External multiplier: accumulate a*x^i for each set bit of b, LSB first.
  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] g, input logic [7:0] f);
    logic [7:0] p;
    logic [7:0] aa;
    p  = f;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? g : 8'h00);
    end
    return p;
  endfunction

  always_comb mul_p = gfmul(mul_a, mul_b, mul_g, mul_f);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation; latency/busy counted in cycles starting with the cycle
  // after the accepting edge. Optionally writes poly mid-run, pulses start
  // in the DONE cycle, or writes poly coincident with start.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] e,
                        input logic [7:0] exp_r, input int exp_lat,
                        input bit poly_mid, input bit start_in_done, input bit poly_with_start);
    int lat;
    int busy_cnt;
    int done_cnt;
    lat = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    din    = a;
    exp_in = e;
    start  = 1'b1;
    if (poly_with_start) begin
      poly_we = 1'b1;
      poly_in = 8'h1D;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    poly_we = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (poly_mid && k == 3) begin
        poly_we = 1'b1;
        poly_in = 8'h1D;
      end
      if (poly_mid && k == 5) poly_we = 1'b0;
      if (start_in_done && lat != 0 && k == lat + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = k;
          check({tag, " dout"}, {24'h0, dout}, {24'h0, exp_r});
          if (start_in_done) start = 1'b1;
        end
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, exp_lat);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " dout hold"}, {24'h0, dout}, {24'h0, exp_r});
  endtask

  initial begin
    int t_done[$];
    int prev_done;
    int dcount;
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    din     = '0;
    exp_in  = '0;
    poly_we = 1'b0;
    poly_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'h0, busy}, 0);
    check("rst done", {31'h0, done}, 0);
    check("rst dout", {24'h0, dout}, 0);
    check("rst mul_a", {24'h0, mul_a}, 0);
    check("rst mul_b", {24'h0, mul_b}, 0);
    check("rst mul_g", {24'h0, mul_g}, 32'h1B);
    check("rst mul_f", {24'h0, mul_f}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Inverse in AES field; poly write during busy must be ignored.
    run_op("inv53", 8'h53, 8'd254, 8'hCA, 16, 1'b1, 1'b0, 1'b0);
    check("poly unchanged", {24'h0, mul_g}, 32'h1B);
    check("idle mul_a", {24'h0, mul_a}, 0);
    run_op("inv02", 8'h02, 8'd254, 8'h8D, 16, 1'b0, 1'b0, 1'b0);
    run_op("inv01", 8'h01, 8'd254, 8'h01, 16, 1'b0, 1'b0, 1'b0);
    run_op("inv00", 8'h00, 8'd254, 8'h00, 16, 1'b0, 1'b0, 1'b0);

    // Exponent corners; start pulsed during DONE is not accepted.
    run_op("02^2", 8'h02, 8'd2, 8'h04, 10, 1'b0, 1'b0, 1'b0);
    run_op("00^0", 8'h00, 8'd0, 8'h01, 9, 1'b0, 1'b1, 1'b0);
    run_op("57^1", 8'h57, 8'd1, 8'h57, 10, 1'b0, 1'b0, 1'b0);

    // Poly write coincident with start: op uses x^8+x^4+x^3+x^2+1.
    run_op("inv02 p11d", 8'h02, 8'd254, 8'h8E, 16, 1'b0, 1'b0, 1'b1);
    check("poly 1D", {24'h0, mul_g}, 32'h1D);

    // Continuous start: one op every 17 cycles, single-cycle done pulses.
    @(negedge clk);
    din       = 8'h02;
    exp_in    = 8'd254;
    start     = 1'b1;
    prev_done = 0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (done) begin
        t_done.push_back(t);
        check("bb dout", {24'h0, dout}, 32'h8E);
        if (prev_done != 0) check("bb done width", 1, 0);
      end
      prev_done = done ? 1 : 0;
    end
    start = 1'b0;
    check("bb done count", t_done.size(), 3);
    if (t_done.size() >= 3) begin
      check("bb gap1", t_done[1] - t_done[0], 17);
      check("bb gap2", t_done[2] - t_done[1], 17);
    end
    repeat (20) @(negedge clk);
    check("bb idle", {31'h0, busy}, 0);

    // Reset mid-operation aborts and restores the poly register.
    @(negedge clk);
    din    = 8'h53;
    exp_in = 8'd254;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre-rst busy", {31'h0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("arst busy", {31'h0, busy}, 0);
    check("arst done", {31'h0, done}, 0);
    check("arst dout", {24'h0, dout}, 0);
    check("arst mul_g", {24'h0, mul_g}, 32'h1B);
    check("arst mul_a", {24'h0, mul_a}, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("arst no done", dcount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gf_pow_seq.md
Name: gf_pow_seq

Overview:
- Sequential controller that computes r = a^e over GF(2^8) by left-to-right square-and-multiply.
- Drives one external combinational GF(2^8) multiplier (8-stage LSB-first unrolled array) one multiplication per clock.
- Inverse is e = 254 (a^-1 = a^254; inv(0) = 0).
- Also owns the multiplier's reduction-polynomial configuration register.

Parameters:
POLY, 8'h1B, reset value of reduction-polynomial register (low byte of x^8 + ..., AES field).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
din  in  8  base a; latched on accepted start
exp_in  in  8  exponent e; latched on accepted start
poly_we  in  1  poly register write strobe; honoured only in IDLE
poly_in  in  8  new reduction polynomial low byte
busy  out  1  high from cycle after accepted start through DONE cycle inclusive
done  out  1  one-cycle pulse, dout valid
dout  out  8  result; holds until next done
mul_a  out  8  multiplier operand a
mul_b  out  8  multiplier operand b
mul_g  out  8  multiplier polynomial, = poly register
mul_f  out  8  multiplier accumulator seed, constant 8'h00
mul_p  in  8  multiplier product (combinational from mul_a/mul_b/mul_g/mul_f)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, dout=0, mul_a=mul_b=0, poly reg=POLY, internal base/exp/r/bit counter cleared. Reset mid-operation aborts; no done pulse.
- Registers: base[7:0], e[7:0], r[7:0], idx[2:0] (bit index), poly[7:0].
- IDLE:
  - start=1 → latch base=din, e=exp_in, r=8'h01, idx=7; go SQR.
  - poly_we=1 → poly<=poly_in. If coincident with start, both happen; the started operation uses the new poly.
- SQR:
  - mul_a=mul_b=r; r<=mul_p at edge.
  - If e[idx]=1 → MUL.
  - Else if idx=0 → DONE.
  - Else idx<=idx-1, stay SQR.
- MUL:
  - mul_a=r, mul_b=base; r<=mul_p.
  - If idx=0 → DONE, else idx<=idx-1 and go SQR.
- DONE:
  - done=1, dout<=r (dout valid same cycle done is high), busy=1.
  - Next state IDLE unconditionally; start in DONE is ignored (not queued).
- Operand outputs are combinational from state + registers; mul_a=mul_b=0 in IDLE and DONE.
- start while busy is ignored. poly_we while busy is ignored (poly unchanged).
- Latency from accepting edge to done-high cycle: 8 SQR + popcount(e) MUL + 1 DONE cycle. e=254 → 16 cycles; e=0 → 9 cycles.
- Arithmetic: all 8-bit; no widening. The multiplier reduces via mul_g internally. The controller never inspects product bits.
- Edge cases:
  - e=0 → result 8'h01 for any a, including a=0.
  - a=0 with e≠0 → 8'h00.
  - idx wrap never occurs: exit on idx=0.
- Minimum throughput: back-to-back ops need one IDLE cycle between DONE and next accepted start.

Test Plan:
- Reset: assert rst_n=0 mid-run (e=254, 5 cycles after start) → busy, done, dout=0 immediately; mul_g=8'h1B; no done pulse follows.
- Inverse, AES field: poly=0x1B, din=0x53, exp_in=254 → dout=0xCA, done exactly 16 cycles after accepting edge, busy high for 16 cycles.
- Inverse edge values: din=0x02 → 0x8D; din=0x01 → 0x01; din=0x00 → 0x00; each with latency 16.
- Exponent corners: din=0x02, e=2 → 0x04 (latency 10); din=0x00, e=0 → 0x01 (latency 9); din=0x57, e=1 → 0x57 (latency 10).
- Poly reconfiguration: poly_we=1, poly_in=0x1D during busy → ignored, result still AES. Then poly_we with 0x1D in IDLE coincident with start, din=0x02, e=254 → dout=0x8E, mul_g=0x1D.
- Handshake: hold start=1 continuously → ops accepted every 17 cycles (16 + IDLE). start pulsed in DONE cycle → not accepted; done pulses exactly one cycle each.
